// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the iterative multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIVZERO_LO = '1;

endpackage

`default_nettype wire

// File: rtl/muldiv_absneg.sv
// ============================================================================
// Module   : muldiv_absneg
// Purpose  : Conditional two's-complement negate (magnitude / sign restore).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_absneg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   input  logic             neg,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? ({WIDTH{1'b0}} - din) : din;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO.
//            Optional macro MULDIV_EARLY_EXIT_EN: multiply leaves CALC early.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Req_EX,
   input  logic             Op_EX,
   input  logic             Signed_EX,
   input  logic [WIDTH-1:0] SrcA_EX,
   input  logic [WIDTH-1:0] SrcB_EX,
   input  logic             HiLoRd_EX,
   input  logic             Kill,
   output logic             StallReq,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 op_q, op_d;
   logic                 sgn_res_q, sgn_res_d;
   logic                 sgn_rem_q, sgn_rem_d;
   logic                 divz_q, divz_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic                 accept;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic                 calc_last;
   logic [2*WIDTH-1:0]   prod_raw, prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
      .din (SrcA_EX),
      .neg (Signed_EX & SrcA_EX[WIDTH-1]),
      .dout(a_mag)
   );

   muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
      .din (SrcB_EX),
      .neg (Signed_EX & SrcB_EX[WIDTH-1]),
      .dout(b_mag)
   );

   assign accept = (state_q == IDLE) & Req_EX & ~Kill;

   // Multiply: accumulator {hi, multiplier}, add multiplicand on LSB then shift right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: accumulator {remainder, dividend}; restoring trial subtract.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;
   assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

`ifdef MULDIV_EARLY_EXIT_EN
   logic mul_rem_nz;

   // Multiplier bits still waiting to be consumed after this step: acc_q[cnt_q:1].
   always_comb begin
      mul_rem_nz = 1'b0;
      for (int i = 0; i < WIDTH-1; i++) begin
         if ((CNT_W'(i) < cnt_q) && acc_q[i+1]) mul_rem_nz = 1'b1;
      end
   end

   assign calc_last = (cnt_q == '0) || ((op_q == OP_MUL) && !mul_rem_nz);
   assign prod_raw  = acc_q >> cnt_q;
`else
   assign calc_last = (cnt_q == '0);
   assign prod_raw  = acc_q;
`endif

   muldiv_absneg #(.WIDTH(2*WIDTH)) u_neg_prod (
      .din (prod_raw),
      .neg (sgn_res_q),
      .dout(prod_fix)
   );

   muldiv_absneg #(.WIDTH(WIDTH)) u_neg_quo (
      .din (acc_q[WIDTH-1:0]),
      .neg (sgn_res_q),
      .dout(quo_fix)
   );

   muldiv_absneg #(.WIDTH(WIDTH)) u_neg_rem (
      .din (acc_q[2*WIDTH-1:WIDTH]),
      .neg (sgn_rem_q),
      .dout(rem_fix)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      op_d      = op_q;
      sgn_res_d = sgn_res_q;
      sgn_rem_d = sgn_rem_q;
      divz_d    = divz_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d     = {{WIDTH{1'b0}}, (Op_EX == OP_DIV) ? a_mag : b_mag};
               b_d       = (Op_EX == OP_DIV) ? b_mag : a_mag;
               op_d      = Op_EX;
               sgn_res_d = Signed_EX & (SrcA_EX[WIDTH-1] ^ SrcB_EX[WIDTH-1]);
               sgn_rem_d = Signed_EX & SrcA_EX[WIDTH-1];
               divz_d    = (SrcB_EX == '0);
               cnt_d     = CNT_W'(WIDTH-1);
               state_d   = CALC;
            end
         end
         CALC: begin
            if (Kill) begin
               state_d = IDLE;
            end else begin
               acc_d = (op_q == OP_DIV) ? div_next : mul_next;
               if (calc_last) state_d = FIX;
               else           cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!Kill) begin
               done_d = 1'b1;
               if (op_q == OP_DIV) begin
                  // Divide-by-zero: remainder sign restore already yields raw dividend.
                  lo_d = divz_q ? DIVZERO_LO[WIDTH-1:0] : quo_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         sgn_res_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         divz_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         op_q      <= op_d;
         sgn_res_q <= sgn_res_d;
         sgn_rem_q <= sgn_rem_d;
         divz_q    <= divz_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign Busy     = (state_q != IDLE);
   assign Done     = done_q;
   assign Hi       = hi_q;
   assign Lo       = lo_q;
   assign StallReq = (Busy | done_q) & (HiLoRd_EX | (Req_EX & ~accept));

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench: directed table, corner sequences, random ops.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Req_EX, Op_EX, Signed_EX, HiLoRd_EX, Kill;
   logic [31:0] SrcA_EX, SrcB_EX;
   logic        StallReq, Busy, Done;
   logic [31:0] Hi, Lo;

   int checks   = 0;
   int failures = 0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Req_EX   (Req_EX),
      .Op_EX    (Op_EX),
      .Signed_EX(Signed_EX),
      .SrcA_EX  (SrcA_EX),
      .SrcB_EX  (SrcB_EX),
      .HiLoRd_EX(HiLoRd_EX),
      .Kill     (Kill),
      .StallReq (StallReq),
      .Busy     (Busy),
      .Done     (Done),
      .Hi       (Hi),
      .Lo       (Lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          op;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-precision arithmetic, returns {hi, lo}.
   function automatic logic [63:0] model(input bit op, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         if (sgn) p = sa * sb;
         else     p = {32'b0, a} * {32'b0, b};
         return p;
      end
      if (b == 32'b0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   function automatic int model_lat(input bit op, input bit sgn, input logic [31:0] b);
      logic [31:0] m;
      int          top;
      m   = (sgn && b[31]) ? (32'd0 - b) : b;
      top = -1;
      for (int i = 0; i < 32; i++) if (m[i]) top = i;
`ifdef MULDIV_EARLY_EXIT_EN
      if (!op) return (top < 0) ? 3 : top + 3;
`endif
      return 34;
   endfunction

   task automatic start_op(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      Req_EX = 1'b1; Op_EX = op; Signed_EX = sgn; SrcA_EX = a; SrcB_EX = b;
      #1;
      chk("accept_nostall", {63'b0, StallReq}, 64'd0);
      tick();
      Req_EX = 1'b0;
   endtask

   // Returns in the Done cycle so a following call exercises back-to-back acceptance.
   task automatic run_op(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output int busy_n);
      start_op(op, sgn, a, b);
      lat = 0; busy_n = 0; hi = '0; lo = '0;
      for (int k = 1; k <= 200; k++) begin
         if (Done) begin
            lat = k; hi = Hi; lo = Lo;
            break;
         end
         if (Busy) busy_n++;
         tick();
      end
   endtask

   initial begin
      vec_t        vecs[8];
      logic [31:0] hi, lo;
      logic [63:0] exp;
      int          lat, busy_n, elat, saw_done;
      bit          op, sgn;
      logic [31:0] a, b;

      vecs[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
      vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
      vecs[5] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 32'h0000_0015};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022};

      rst_n = 1'b0; Req_EX = 1'b0; Op_EX = 1'b0; Signed_EX = 1'b0;
      SrcA_EX = '0; SrcB_EX = '0; HiLoRd_EX = 1'b0; Kill = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      chk("reset_busy",  {63'b0, Busy},     64'd0);
      chk("reset_done",  {63'b0, Done},     64'd0);
      chk("reset_stall", {63'b0, StallReq}, 64'd0);
      chk("reset_hi",    {32'b0, Hi},       64'd0);
      chk("reset_lo",    {32'b0, Lo},       64'd0);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, hi, lo, lat, busy_n);
         elat = model_lat(vecs[i].op, vecs[i].sgn, vecs[i].b);
         chk($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].hi});
         chk($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].lo});
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(elat));
         chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(elat - 1));
      end

      // HI/LO read stalls through the Done cycle of an in-flight multiply
      tick();
      a = 32'h1234_5678; b = 32'h8000_0001;
      exp  = model(1'b0, 1'b0, a, b);
      elat = model_lat(1'b0, 1'b0, b);
      start_op(1'b0, 1'b0, a, b);
      for (int k = 1; k <= elat + 1; k++) begin
         if (k >= 2) HiLoRd_EX = 1'b1;
         #1;
         if (k >= 2) chk($sformatf("rd_stall_k%0d", k), {63'b0, StallReq}, {63'b0, (k <= elat)});
         if (k == elat) chk("rd_done", {63'b0, Done}, 64'd1);
         tick();
      end
      HiLoRd_EX = 1'b0;
      chk("rd_hilo", {Hi, Lo}, exp);

      // Restore HI/LO = 0x11/0x22, then kill a divide in flight
      run_op(1'b1, 1'b0, 32'h451, 32'h20, hi, lo, lat, busy_n);
      chk("kill_setup", {hi, lo}, 64'h0000_0011_0000_0022);
      start_op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003);
      repeat (9) tick();
      chk("kill_busy_before", {63'b0, Busy}, 64'd1);
      Kill = 1'b1;
      tick();
      Kill = 1'b0;
      chk("kill_idle", {63'b0, Busy}, 64'd0);
      saw_done = 0;
      repeat (40) begin
         if (Done) saw_done = 1;
         tick();
      end
      chk("kill_no_done", 64'(saw_done), 64'd0);
      chk("kill_hilo", {Hi, Lo}, 64'h0000_0011_0000_0022);

      // Kill in IDLE overrides a request
      Req_EX = 1'b1; Op_EX = 1'b0; SrcA_EX = 32'd9; SrcB_EX = 32'd9; Kill = 1'b1;
      tick();
      Req_EX = 1'b0; Kill = 1'b0;
      chk("kill_idle_req", {63'b0, Busy}, 64'd0);

      // Reset in the middle of a multiply
      start_op(1'b0, 1'b0, 32'h5, 32'h8000_0001);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      chk("rst_mid_busy", {63'b0, Busy}, 64'd0);
      chk("rst_mid_hilo", {Hi, Lo}, 64'd0);
      chk("rst_mid_done", {63'b0, Done}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Randomized operations against the arithmetic reference
      for (int n = 0; n < 40; n++) begin
         op  = 1'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(0, 15));
            2:       b = 32'd0 - 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_op(op, sgn, a, b, hi, lo, lat, busy_n);
         exp = model(op, sgn, a, b);
         chk($sformatf("rnd%0d_op%0d_s%0d_a%0h_b%0h_hilo", n, op, sgn, a, b), {hi, lo}, exp);
         chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(model_lat(op, sgn, b)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the MIPS pipeline; owns the HI/LO architectural registers. It accepts a MULT/MULTU/DIV/DIVU request from EX and runs a 32-iteration shift-add or restoring-divide datapath. It raises a stall request to the hazard logic while a new request or an MFHI/MFLO read would otherwise consume stale HI/LO.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- Req_EX  in  1  MULT/DIV present in EX; held by pipeline while stalled.
- Op_EX  in  1  0 = multiply, 1 = divide.
- Signed_EX  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- SrcA_EX  in  WIDTH  multiplicand / dividend.
- SrcB_EX  in  WIDTH  multiplier / divisor.
- HiLoRd_EX  in  1  MFHI/MFLO in EX.
- Kill  in  1  pipeline flush; aborts in-flight operation.
- StallReq  out  1  to hazard unit (feeds AnyStall).
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when HI/LO are updated.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: Req_EX=1 and Kill=0 latch the operands.
  - Signed ops latch magnitudes, plus sign flags for the quotient/product (sA^sB) and the remainder (sA).
  - The iteration counter loads WIDTH-1, then go to CALC.
- CALC, multiply: 2*WIDTH accumulator, radix-2 shift-add, one multiplier bit per cycle.
- CALC, divide: restoring; each cycle shifts the remainder left, trial-subtracts the divisor, and sets the quotient bit if the result is non-negative.
- CALC exits to FIX when the counter reaches 0.
- FIX:
  - Apply the negations.
  - Write Hi/Lo: multiply gives Hi = product[2W-1:W], Lo = product[W-1:0]; divide gives Lo = quotient, Hi = remainder.
  - Pulse Done, return to IDLE.
- Divide by zero: Lo = all ones, Hi = dividend (raw SrcA, unsigned and signed). No exception.
- Signed overflow (-2^(W-1) / -1): Lo = 0x80000000, Hi = 0, which falls out of the magnitude arithmetic.
- StallReq = (Busy | Done) & (Req_EX | HiLoRd_EX), except when Req_EX is the request being accepted this cycle in IDLE.
  - The Done cycle still stalls a reader for one cycle. Reads are served from Hi/Lo in the following cycle, which avoids a combinational bypass.
- Kill in CALC/FIX: go to IDLE next cycle. Hi/Lo unchanged, no Done.
- Kill in IDLE overrides Req_EX, so the request is not accepted.
- Req_EX while Busy: ignored (StallReq holds it). It is accepted in the first IDLE cycle.

## Timing
- Request accepted at edge N.
- Busy is high cycles N+1..N+W+1: CALC for W cycles, then FIX.
- Hi/Lo are valid and Done is high in cycle N+W+2, the register output after the FIX edge. Total latency is W+2 = 34 cycles.
- Back-to-back: the next request can be accepted in the Done cycle.
- Reset: state IDLE, Busy=0, Done=0, StallReq=0, Hi=0, Lo=0, counter=0.
- Reset mid-operation takes effect at the next edge and discards the operation.

## Configuration
- MULDIV_EARLY_EXIT_EN defined:
  - Multiply leaves CALC for FIX as soon as the remaining unshifted multiplier bits are all zero, with the product shifted into place in FIX.
  - Latency is (index of highest set multiplier-magnitude bit + 1) + 2, minimum 3 (multiplier 0 → CALC 1 cycle).
  - Divide is unchanged.
- Undefined: fixed W+2 latency for all operations.

## Structure
- Package muldiv_pkg:
  - state enum (IDLE/CALC/FIX);
  - op encoding constants (OP_MUL=0, OP_DIV=1);
  - DIVZERO_LO constant (all ones).
- One sub-module, muldiv_absneg: conditional two's-complement negate, parameterised by WIDTH. It is instantiated for operand magnitudes and for the FIX-stage result correction.
- Everything else is a single FSM plus datapath in muldiv_sequencer.

## Test plan
- Unsigned multiply 0xFFFFFFFF × 0x00000002:
  - Hi=0x00000001, Lo=0xFFFFFFFE.
  - Done exactly 34 cycles after acceptance, Busy high 33 cycles.
- Signed multiply -3 × 5: Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Signed divide -7 / 2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- Divide 10 / 0 (signed and unsigned): Lo=0xFFFFFFFF, Hi=0x0000000A. Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- HiLoRd_EX asserted 2 cycles after a multiply starts:
  - StallReq high through the Done cycle, low the cycle after.
  - Hi/Lo show the new product.
- Kill at cycle 10 of a divide (prior Hi=0x11, Lo=0x22):
  - IDLE next cycle, no Done, Hi/Lo stay 0x11/0x22.
- rst_n low at cycle 5 of a multiply: next cycle Busy=0, Hi=Lo=0. With MULDIV_EARLY_EXIT_EN, 7 × 3 gives Lo=21 with Done at cycle 4.
